// File: rtl/fsm_xy_encoder_pkg.sv
// Shared constants for the x/y symbol encoder and its downstream Mealy FSM:
// one-hot state codes, symbol codes and the state/bit -> symbol/next-state table.
package fsm_xy_encoder_pkg;

  localparam logic [3:0] S0 = 4'b0001;
  localparam logic [3:0] S1 = 4'b0010;
  localparam logic [3:0] S2 = 4'b0100;
  localparam logic [3:0] S3 = 4'b1000;

  localparam logic [1:0] SYM_X    = 2'b10;
  localparam logic [1:0] SYM_Y    = 2'b01;
  localparam logic [1:0] SYM_IDLE = 2'b00;

  typedef enum logic [1:0] {
    CTL_IDLE = 2'd0,
    CTL_SEND = 2'd1,
    CTL_GAP  = 2'd2
  } ctl_state_e;

  // Returns {xy, next_state}; a non-one-hot state yields no symbol and S0.
  function automatic logic [5:0] next_sym(input logic [3:0] state, input logic b);
    logic [5:0] r;
    case (state)
      S0:      r = b ? {SYM_Y, S3} : {SYM_X, S2};
      S1:      r = b ? {SYM_X, S2} : {SYM_Y, S3};
      S2:      r = b ? {SYM_Y, S3} : {SYM_X, S1};
      S3:      r = b ? {SYM_X, S1} : {SYM_Y, S2};
      default: r = {SYM_IDLE, S0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fsm_xy_model.sv
// Shadow copy of the downstream FSM state: symbol lookup for the current bit
// plus the state register with advance, clear and illegal-state recovery.
module fsm_xy_model
  import fsm_xy_encoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_bit,
  input  logic       i_en,
  input  logic       i_clr,
  output logic [1:0] o_sym,
  output logic [3:0] o_state,
  output logic       o_illegal
);

  logic [3:0] r_state;
  logic [5:0] w_lookup;

  assign w_lookup  = next_sym(r_state, i_bit);
  assign o_sym     = w_lookup[5:4];
  assign o_state   = r_state;
  assign o_illegal = ~$onehot(r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S0;
    end else if (o_illegal || i_clr) begin
      r_state <= S0;
    end else if (i_en) begin
      r_state <= w_lookup[3:0];
    end
  end

endmodule

// File: rtl/fsm_xy_encoder.sv
// Serialises handshaken data words into x/y symbols so the downstream FSM
// emits each bit on z; also predicts z and manages FSM resynchronisation.
module fsm_xy_encoder
  import fsm_xy_encoder_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              resync,
  output logic              x,
  output logic              y,
  output logic              sym_valid,
  output logic              expect_z,
  output logic              fsm_rst,
  output logic              busy,
  output logic [3:0]        model_state
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP);

  ctl_state_e        r_ctl;
  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic [GW-1:0]     r_gap;
  logic              r_live;
  logic              r_pend;
  logic              r_fsm_rst;
  logic              r_x;
  logic              r_y;
  logic              r_sym_valid;
  logic              r_expect_z;

  logic              w_last;
  logic              w_ready_slot;
  logic              w_accept;
  logic              w_emit;
  logic              w_apply;
  logic              w_bit;
  logic              w_illegal;
  logic [1:0]        w_sym;
  logic [3:0]        w_model;

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // r_cnt counts symbols already on x/y, so w_last marks the final symbol cycle.
  assign w_last = (r_ctl == CTL_SEND) && (r_cnt == CNT_LAST);

  always_comb begin
    w_ready_slot = 1'b0;
    case (r_ctl)
      CTL_IDLE: w_ready_slot = 1'b1;
      CTL_SEND: w_ready_slot = (GAP == 0) && w_last;
      CTL_GAP:  w_ready_slot = (r_gap == GAP_LAST);
      default:  w_ready_slot = 1'b0;
    endcase
  end

  assign in_ready = w_ready_slot & r_live & ~r_pend & ~resync & ~r_fsm_rst & ~w_illegal;
  assign w_accept = in_valid & in_ready;
  assign w_bit    = w_accept ? head_bit(in_data) : head_bit(r_shift);
  assign w_emit   = w_accept | ((r_ctl == CTL_SEND) & ~w_last & ~w_illegal);
  assign w_apply  = (r_ctl == CTL_IDLE) & r_pend & ~w_illegal;

  fsm_xy_model u_model (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_bit     (w_bit),
    .i_en      (w_emit),
    .i_clr     (w_apply),
    .o_sym     (w_sym),
    .o_state   (w_model),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl       <= CTL_IDLE;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_live      <= 1'b0;
      r_pend      <= 1'b0;
      r_fsm_rst   <= 1'b0;
      r_x         <= 1'b0;
      r_y         <= 1'b0;
      r_sym_valid <= 1'b0;
      r_expect_z  <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_pend      <= (r_pend & ~w_apply) | resync;
      r_fsm_rst   <= w_apply;
      r_sym_valid <= w_emit;
      r_expect_z  <= w_emit & w_bit;
      {r_x, r_y}  <= w_emit ? w_sym : SYM_IDLE;
      if (w_accept) begin
        r_ctl <= CTL_SEND;
        r_cnt <= CW'(1);
      end else begin
        case (r_ctl)
          CTL_SEND: begin
            if (w_emit) begin
              r_cnt <= r_cnt + 1'b1;
            end else if (w_last) begin
              r_cnt <= '0;
              if (GAP > 0) begin
                r_ctl <= CTL_GAP;
                r_gap <= GW'(1);
              end else begin
                r_ctl <= CTL_IDLE;
              end
            end
          end
          CTL_GAP: begin
            if (r_gap == GAP_LAST) r_ctl <= CTL_IDLE;
            else                   r_gap <= r_gap + 1'b1;
          end
          default: r_ctl <= CTL_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= drop_head(in_data);
    end else if (w_emit) begin
      r_shift <= drop_head(r_shift);
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign sym_valid   = r_sym_valid;
  assign expect_z    = r_expect_z;
  assign fsm_rst     = r_fsm_rst;
  assign busy        = (r_ctl != CTL_IDLE);
  assign model_state = w_model;

endmodule

// File: tb/tb_fsm_xy_encoder.sv
// Bench for fsm_xy_encoder: vector table, hand-written corner sequences, a
// scoreboard of expected symbols and a behavioural downstream x/y FSM.
module tb_fsm_xy_encoder;

  localparam logic [3:0] S0 = 4'b0001;
  localparam logic [3:0] S1 = 4'b0010;
  localparam logic [3:0] S2 = 4'b0100;
  localparam logic [3:0] S3 = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_ready, resync;
  logic       x, y, sym_valid, expect_z, fsm_rst, busy;
  logic [3:0] model_state;

  logic [7:0] d2;
  logic       v2, r2, rs2, x2, y2, sv2, z2, fr2, busy2;
  logic [3:0] ms2;

  fsm_xy_encoder #(.DATA_W(8), .GAP(0), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .resync(resync), .x(x), .y(y), .sym_valid(sym_valid),
    .expect_z(expect_z), .fsm_rst(fsm_rst), .busy(busy), .model_state(model_state)
  );

  fsm_xy_encoder #(.DATA_W(8), .GAP(2), .MSB_FIRST(1'b1)) dut_gap (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2),
    .in_ready(r2), .resync(rs2), .x(x2), .y(y2), .sym_valid(sv2),
    .expect_z(z2), .fsm_rst(fr2), .busy(busy2), .model_state(ms2)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] xy;
    logic       z;
  } sym_t;

  sym_t       exp_q[$];
  sym_t       mon_e;
  logic [3:0] ref_st;
  bit         rs_seen;
  logic [3:0] dn_st;
  logic       dn_z;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Encoder reference: state, bit -> {xy, next}
  function automatic logic [5:0] ref_step(input logic [3:0] st, input logic b);
    case ({st, b})
      {S0, 1'b0}: return {2'b10, S2};
      {S0, 1'b1}: return {2'b01, S3};
      {S1, 1'b0}: return {2'b01, S3};
      {S1, 1'b1}: return {2'b10, S2};
      {S2, 1'b0}: return {2'b10, S1};
      {S2, 1'b1}: return {2'b01, S3};
      {S3, 1'b0}: return {2'b01, S2};
      {S3, 1'b1}: return {2'b10, S1};
      default:    return {2'b00, S0};
    endcase
  endfunction

  // Downstream Mealy FSM as seen from its x/y inputs
  function automatic logic [4:0] dn_step(input logic [3:0] st, input logic [1:0] xy);
    case ({st, xy})
      {S0, 2'b10}: return {1'b0, S2};
      {S0, 2'b01}: return {1'b1, S3};
      {S1, 2'b01}: return {1'b0, S3};
      {S1, 2'b10}: return {1'b1, S2};
      {S2, 2'b10}: return {1'b0, S1};
      {S2, 2'b01}: return {1'b1, S3};
      {S3, 2'b01}: return {1'b0, S2};
      {S3, 2'b10}: return {1'b1, S1};
      default:     return {1'b0, st};
    endcase
  endfunction

  logic [4:0] dn_nx;
  always_comb begin
    dn_nx = dn_step(dn_st, {x, y});
    dn_z  = dn_nx[4];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dn_st <= S0;
    else if (fsm_rst) dn_st <= S0;
    else              dn_st <= dn_nx[3:0];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("xy_never_11", {31'b0, x & y}, 32'd0);
      if (sym_valid) begin
        chk("dnfsm_z_vs_expect_z", {31'b0, dn_z}, {31'b0, expect_z});
        if (exp_q.size() == 0) begin
          chk("sym_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_xy", {30'b0, x, y}, {30'b0, mon_e.xy});
          chk("sb_z", {31'b0, expect_z}, {31'b0, mon_e.z});
        end
      end else begin
        chk("idle_xy_00", {30'b0, x, y}, 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] d, output int waited);
    logic [5:0] r;
    sym_t       e;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    waited = 0;
    while (!in_ready && waited < 60) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (rs_seen) begin
      ref_st  = S0;
      rs_seen = 1'b0;
    end
    for (int k = 7; k >= 0; k--) begin
      r    = ref_step(ref_st, d[k]);
      e.xy = r[5:4];
      e.z  = d[k];
      exp_q.push_back(e);
      ref_st = r[3:0];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    resync   = 1'b0;
    v2       = 1'b0;
    exp_q.delete();
    ref_st  = S0;
    rs_seen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    bit         do_rst;
    logic [7:0] data;
    logic [15:0] xy;
    logic [3:0] fin;
  } vec_t;

  vec_t tbl[4];
  int   w;
  int   n;

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 16'b01_01_01_01_10_10_10_10, S2};
    tbl[1] = '{1'b1, 8'h00, 16'b10_10_01_01_10_01_01_10, S1};
    tbl[2] = '{1'b0, 8'hFF, 16'b10_01_10_10_01_10_10_01, S3};
    tbl[3] = '{1'b0, 8'h3C, 16'b01_10_10_01_10_10_10_01, S3};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; resync = 1'b0;
    v2 = 1'b0; d2 = '0; rs2 = 1'b0; ref_st = S0; rs_seen = 1'b0;

    @(negedge clk);
    chk("rst_xy", {30'b0, x, y}, 32'd0);
    chk("rst_sym_valid", {31'b0, sym_valid}, 32'd0);
    chk("rst_expect_z", {31'b0, expect_z}, 32'd0);
    chk("rst_fsm_rst", {31'b0, fsm_rst}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_model_state", {28'b0, model_state}, {28'b0, S0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, in_ready}, 32'd1);

    // GAP=2 instance: two held words must be separated by exactly two 00 cycles
    d2 = 8'hA5; v2 = 1'b1;
    #1;
    chk("gap_ready_idle", {31'b0, r2}, 32'd1);
    @(negedge clk);
    d2 = 8'h3C;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("gap_sym_valid", {31'b0, sv2}, {31'b0, (k < 8) || (k >= 10 && k < 18)});
      if (k == 8 || k == 9) begin
        chk("gap_xy_00", {30'b0, x2, y2}, 32'd0);
        chk("gap_busy", {31'b0, busy2}, 32'd1);
      end
      if (k == 7 || k == 8) chk("gap_ready_low", {31'b0, r2}, 32'd0);
      if (k == 9) chk("gap_ready_last", {31'b0, r2}, 32'd1);
      if (k == 10) v2 = 1'b0;
      @(negedge clk);
    end

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].do_rst) do_reset();
      send(tbl[i].data, w);
      chk("tbl_latency", {31'b0, sym_valid}, 32'd1);
      for (int k = 0; k < 8; k++) begin
        chk("tbl_xy", {30'b0, x, y}, {30'b0, tbl[i].xy[15-2*k -: 2]});
        chk("tbl_z", {31'b0, expect_z}, {31'b0, tbl[i].data[7-k]});
        if (k < 7) chk("tbl_ready_mid", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
      end
      chk("tbl_final_state", {28'b0, model_state}, {28'b0, tbl[i].fin});
    end

    // back-to-back words with GAP=0
    do_reset();
    send(8'hA5, w);
    send(8'h3C, w);
    chk("b2b_ready_at_sym8", w, 32'd7);
    chk("b2b_no_gap", {31'b0, sym_valid}, 32'd1);
    repeat (7) begin
      @(negedge clk);
      chk("b2b_contiguous", {31'b0, sym_valid}, 32'd1);
    end
    @(negedge clk);
    chk("b2b_then_idle", {31'b0, sym_valid}, 32'd0);

    // resync mid-word is deferred until IDLE
    send(8'h5A, w);
    @(negedge clk);
    @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    rs_seen = 1'b1;
    chk("resync_word_continues", {31'b0, busy}, 32'd1);
    n = 0;
    while (!fsm_rst && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("resync_delay", n, 32'd6);
    chk("resync_pulse", {31'b0, fsm_rst}, 32'd1);
    chk("resync_state", {28'b0, model_state}, {28'b0, S0});
    chk("resync_ready_low", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("resync_one_cycle", {31'b0, fsm_rst}, 32'd0);
    chk("resync_ready_back", {31'b0, in_ready}, 32'd1);

    // resync and in_valid together in IDLE: the word waits
    resync = 1'b1; in_data = 8'h96; in_valid = 1'b1;
    #1;
    chk("resync_wins", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    resync = 1'b0;
    rs_seen = 1'b1;
    send(8'h96, w);
    chk("resync_word_waited", w, 32'd2);
    repeat (8) @(negedge clk);

    // asynchronous reset at symbol 4
    send(8'hC3, w);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    ref_st = S0; rs_seen = 1'b0; in_valid = 1'b0;
    #1;
    chk("arst_xy", {30'b0, x, y}, 32'd0);
    chk("arst_sym_valid", {31'b0, sym_valid}, 32'd0);
    chk("arst_expect_z", {31'b0, expect_z}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_state", {28'b0, model_state}, {28'b0, S0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h81, w);
    chk("accept_after_arst", w, 32'd0);
    repeat (8) @(negedge clk);

    // random words with random resyncs
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        rs_seen = 1'b1;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(8'($urandom), w);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        rs_seen = 1'b1;
      end
    end
    repeat (12) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fsm_xy_encoder.md
Name: fsm_xy_encoder

Overview:
Transmit-side companion to the team's 4-state x/y Mealy FSM. It accepts data words over a valid/ready handshake and serialises each bit into one x/y symbol (2'b10 or 2'b01) chosen so that the downstream FSM emits exactly that bit on z. An internal model of the FSM state selects each symbol and predicts z, so a checker can compare the FSM's z against expect_z.

Parameters:
DATA_W, 8, bits per input word / symbols per word
GAP, 0, idle (x,y=00) cycles inserted after each word; 0 = back-to-back words
MSB_FIRST, 1, 1 = send bit DATA_W-1 first, 0 = send bit 0 first

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  DATA_W  word to transmit
in_valid  input  1  in_data valid
in_ready  output  1  word accepted on a clk edge where in_valid && in_ready
resync  input  1  request to return model and downstream FSM to S0
x  output  1  symbol bit x (registered)
y  output  1  symbol bit y (registered)
sym_valid  output  1  x/y is a data symbol this cycle (01 or 10)
expect_z  output  1  z the downstream FSM produces for the current symbol
fsm_rst  output  1  one-cycle pulse to drive the downstream FSM reset
busy  output  1  word in flight (SEND or GAP)
model_state  output  4  one-hot model state (S0=0001, S1=0010, S2=0100, S3=1000)

Behaviour:
- Reset (rst_n low, async): x=y=0, sym_valid=0, expect_z=0, fsm_rst=0, busy=0, in_ready=0 for the reset cycle, then 1 in IDLE. model_state=S0, control FSM=IDLE, bit counter=0, resync pending=0.
- Control FSM states: IDLE, SEND, GAP.
- IDLE: x,y=00, in_ready=1 unless resync is pending or asserted. On accept, load shift register, go to SEND. The first symbol appears on x/y in the cycle after the accept edge (1-cycle latency).
- SEND: each cycle emits one symbol for the current bit b, then updates the model state and advances the counter. Symbol/next-state/expect_z rules (state, b -> xy, next):
  S0: b=0 -> 10, S2; b=1 -> 01, S3.
  S1: b=0 -> 01, S3; b=1 -> 10, S2.
  S2: b=0 -> 10, S1; b=1 -> 01, S3.
  S3: b=0 -> 01, S2; b=1 -> 10, S1.
  expect_z=b, sym_valid=1. After symbol DATA_W-1: go to GAP if GAP>0, else IDLE.
- Back-to-back (GAP=0): in_ready is also 1 during the last symbol of a word. If a word is accepted then, its first symbol follows with no 00 cycle. Otherwise go to IDLE.
- GAP: x,y=00, sym_valid=0 for exactly GAP cycles, model unchanged, then IDLE.
- resync: sampled every cycle into a pending flag. It takes effect only in IDLE, never mid-word. When applied, model_state becomes S0 and fsm_rst pulses high for 1 cycle. in_ready stays 0 that cycle and while the flag is pending.
- resync and in_valid both high in IDLE: resync wins and the word waits.
- Illegal model state (not one-hot): force S0 on the next edge and emit no symbol that cycle.
- Never emit 00 or 11 as a data symbol. Outputs are 00 whenever sym_valid=0.
- Reset mid-word aborts the word with no completion. The downstream FSM must be reset externally.

Decomposition:
- Shared package: one-hot state constants S0..S3 (shared with the FSM), symbol constants SYM_X=2'b10 and SYM_Y=2'b01, and a pure function next_sym(state, bit) returning {xy, next_state}.
- Sub-module fsm_xy_model: combinational state/bit to symbol/next-state lookup plus the model-state register with enable and illegal-state recovery.
- Top holds the handshake, shift register, counter and GAP timer.

Test Plan:
- Reset, then 0xA5 from S0, MSB_FIRST=1 -> xy = 01,01,01,01,10,10,10,10 on 8 consecutive cycles starting 1 cycle after accept; expect_z = 1,0,1,0,0,1,0,1; final model_state = S2.
- Reset, then 0x00 from S0 -> xy = 10,10,01,01,10,01,01,10; final model_state = S1. Then 0xFF follows from S1 with no reset between words.
- GAP=0, in_valid held with 0xA5 then 0x3C -> 16 contiguous sym_valid cycles and in_ready high on symbol 8. GAP=2 -> exactly two 00 cycles between words.
- resync pulsed mid-word -> word completes unchanged. Then in IDLE: fsm_rst high 1 cycle, model_state=S0, in_ready low that cycle.
- Drive the outputs into the team FSM and compare its z against the delayed expect_z for 1000 random words with random resyncs -> zero mismatches, and x/y never 11.
- rst_n asserted at symbol 4 -> outputs 0 and model_state=S0 immediately (async), and accept resumes after release.
